execute_sequencer: RTL
======================

Name: execute_sequencer

Overview:
Sits directly downstream of the instruction decoder and consumes its decoded control bundle. Owns the 8-entry register file, with R6 serving as PC. Runs one instruction at a time through execute, optional RAM access, and writeback. Updates PC and produces the cond_bits that feed back into the decoder for branch resolution.

Parameters:
DATA_W, 16, datapath and register width
NUM_REGS, 8, register file depth; R0 always reads 0
PC_REG, 6, register index used as program counter

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
instr_valid  in  1  decoded bundle valid
instr_ready  out  1  sequencer can accept a bundle
destination_reg  in  3  decoder destination register
first_reg  in  3  decoder operand-A register
second_reg  in  3  decoder operand-B register
offset  in  16  decoder sign-extended offset
alu_op  in  3  decoder ALU op
ram_read  in  1  decoder load flag
ram_write  in  1  decoder store flag
cond_bits  out  3  flags to decoder: [0]=less, [1]=greater, [2]=zero
pc  out  16  current R6, drives fetch
mem_req  out  1  RAM request
mem_we  out  1  1=write, 0=read
mem_addr  out  16  RAM word address
mem_wdata  out  16  store data
mem_rdata  in  16  load data
mem_ack  in  1  RAM completion

Behaviour:
- Reset (async, reset_n=0):
  - all registers = 0, so pc = 0; cond_bits = 0.
  - state = IDLE; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; instr_ready = 1.
- States and transitions:
  - IDLE: instr_ready = 1. On instr_valid, latch the whole bundle and go to EXEC.
  - EXEC: compute result and address. If ram_read or ram_write, go to MEM; else go to WB.
  - MEM: mem_req = 1, with mem_we, mem_addr and mem_wdata held stable. Stay until mem_ack = 1. mem_ack in the first MEM cycle is legal. Then go to WB.
  - WB: commit results and return to IDLE.
- instr_ready = 1 only in IDLE. Bundle inputs are ignored outside the accept cycle.
- Latency: ALU/branch instructions take 3 cycles, accept to next accept. Memory instructions take 3 cycles plus MEM cycles.
- Operands:
  - A = R[first_reg]; B = R[second_reg] + offset (16-bit wrap).
  - R0 reads as 0 in all cases.
- ALU operations:
  - 100: A+B.
  - 101: A−B.
  - 110: A&B.
  - 111: A|B.
  - 000 (shift): offset signed. Positive n shifts A left logically by n. Negative shifts right logically by |n|. 0 passes A through. |n| ≥ 16 gives 0.
  - 001–011: treated as add.
- Load: mem_addr = R[first_reg] + offset. In WB, R[destination_reg] ← mem_rdata.
- Store: mem_addr = R[destination_reg] + offset; mem_wdata = R[first_reg]. No register write.
- PC and register writeback in WB:
  - If destination_reg == PC_REG and not a store, PC ← result (branch/jump). The "not taken" offset of 1 therefore yields PC+1.
  - Otherwise PC ← PC+1, and R[destination_reg] ← result or load data.
  - Writes to R0 are discarded.
- Flag update in WB: only for non-memory instructions with destination_reg ∉ {0, PC_REG}.
  - less = result[15].
  - zero = (result == 0).
  - greater = !less && !zero.
  - Branches, loads, stores and no-ops leave flags unchanged.
- cond_bits are registered and stable from WB onward, so the decoder sees updated flags on the next accepted instruction.
- Arithmetic: all 16-bit, carries and overflow discarded.
- mem_ack outside MEM is ignored.
- Reset asserted mid-MEM drops mem_req asynchronously and abandons the access; no partial writeback occurs.

Decomposition:
- Shared package holds:
  - ALU op codes (ALU_SHIFT=000, ALU_ADD=100, ALU_SUB=101, ALU_AND=110, ALU_OR=111).
  - Flag bit indices (FLAG_LT=0, FLAG_GT=1, FLAG_Z=2).
  - REG_ZERO=0, PC_REG=6.
  - State encoding {IDLE, EXEC, MEM, WB}.
- One sub-module: regfile. It has 2 async read ports plus a third read for store base/data, and 1 sync write port. It owns the R0-zero rule and the dedicated PC increment path and output.

Test Plan:
1. Reset, then immediate: dest=1, first=0, offset=5, op=100 → R1=5, pc=1, cond_bits=3'b010, instr_ready high again 3 cycles after accept.
2. Subtract to zero, then negative: R1=5; op=101 with dest=2, first=1, second=1 → R2=0, cond=3'b100. Then first=0, second=1 → R2=0xFFFB, cond=3'b001.
3. Shift: R1=0x0003. offset=+4 → 0x0030. offset=−1 (0xFFFF) on 0x8000 → 0x4000. offset=−16 → 0.
4. Load with wait states: R3=0x0100, offset=2, ram_read; ack after 3 MEM cycles with rdata=0xBEEF → mem_addr=0x0102, mem_we=0, mem_req high exactly 3 cycles, R4=0xBEEF, flags unchanged.
5. Store and branch: store dest(base)=3, first(data)=4, offset=−1 → mem_addr=0x00FF, wdata=0xBEEF, mem_we=1, no register change. Then branch bundle dest=6, first=6, offset=0xFFFC at pc=10 → pc=6.
6. Reset mid-MEM: assert reset_n=0 while mem_req=1 → mem_req falls the same cycle, all registers read 0, state IDLE, late mem_ack ignored.

Source files
------------

// File: rtl/execute_sequencer_pkg.sv
// Shared definitions for the execute sequencer: register indices, ALU codes,
// flag positions, FSM encoding and the pure combinational ALU/flag helpers.
package execute_sequencer_pkg;

  localparam int DATA_W    = 16;
  localparam int NUM_REGS  = 8;
  localparam int REG_IDX_W = 3;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 3'd0;
  localparam logic [REG_IDX_W-1:0] PC_REG   = 3'd6;

  localparam logic [2:0] ALU_SHIFT = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_SUB   = 3'b101;
  localparam logic [2:0] ALU_AND   = 3'b110;
  localparam logic [2:0] ALU_OR    = 3'b111;

  localparam int FLAG_LT = 0;
  localparam int FLAG_GT = 1;
  localparam int FLAG_Z  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MEM  = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // Shift distance comes from the raw offset: sign picks direction, |n| >= 16 clears.
  function automatic logic [DATA_W-1:0] alu_compute(
    input logic [2:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [DATA_W-1:0] off
  );
    logic [DATA_W-1:0] mag;
    logic [DATA_W-1:0] res;
    mag = off;
    res = a + b;
    case (op)
      ALU_ADD: res = a + b;
      ALU_SUB: res = a - b;
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_SHIFT: begin
        if (off[DATA_W-1]) begin
          mag = 16'd0 - off;
          if (mag >= 16'd16) res = 16'd0;
          else               res = a >> mag[3:0];
        end else begin
          mag = off;
          if (mag >= 16'd16) res = 16'd0;
          else               res = a << mag[3:0];
        end
      end
      default: res = a + b;
    endcase
    return res;
  endfunction

  function automatic logic [2:0] flags_of(input logic [DATA_W-1:0] r);
    logic [2:0] f;
    f          = 3'b000;
    f[FLAG_LT] = r[DATA_W-1];
    f[FLAG_Z]  = (r == 16'd0);
    f[FLAG_GT] = !f[FLAG_LT] && !f[FLAG_Z];
    return f;
  endfunction

endpackage

// File: rtl/execute_sequencer_regfile.sv
// Eight-entry register file: three async reads, one sync write, R0 hard-wired
// to zero, and a dedicated increment path for the PC register.
module execute_sequencer_regfile
  import execute_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [REG_IDX_W-1:0] ra_addr,
  input  logic [REG_IDX_W-1:0] rb_addr,
  input  logic [REG_IDX_W-1:0] rc_addr,
  output logic [DATA_W-1:0]    ra_data,
  output logic [DATA_W-1:0]    rb_data,
  output logic [DATA_W-1:0]    rc_data,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic                 pc_inc,
  output logic [DATA_W-1:0]    pc
);

  logic [DATA_W-1:0] regs_r [NUM_REGS];

  assign ra_data = (ra_addr == REG_ZERO) ? 16'd0 : regs_r[ra_addr];
  assign rb_data = (rb_addr == REG_ZERO) ? 16'd0 : regs_r[rb_addr];
  assign rc_data = (rc_addr == REG_ZERO) ? 16'd0 : regs_r[rc_addr];
  assign pc      = regs_r[PC_REG];

  // Register storage; the sequencer never asserts we and pc_inc on the PC together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= 16'd0;
    end else begin
      if (we && (waddr != REG_ZERO)) regs_r[waddr] <= wdata;
      if (pc_inc) regs_r[PC_REG] <= regs_r[PC_REG] + 16'd1;
    end
  end

endmodule

// File: rtl/execute_sequencer.sv
// Executes one decoded bundle at a time through EXEC, optional MEM and WB,
// maintaining the register file, PC and the condition flags for the decoder.
module execute_sequencer
  import execute_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [2:0]  destination_reg,
  input  logic [2:0]  first_reg,
  input  logic [2:0]  second_reg,
  input  logic [15:0] offset,
  input  logic [2:0]  alu_op,
  input  logic        ram_read,
  input  logic        ram_write,
  output logic [2:0]  cond_bits,
  output logic [15:0] pc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  state_e            state_r;
  state_e            next_state_s;

  logic [2:0]        dest_r;
  logic [2:0]        first_r;
  logic [2:0]        second_r;
  logic [15:0]       offset_r;
  logic [2:0]        op_r;
  logic              rd_r;
  logic              wr_r;

  logic [15:0]       a_data_s;
  logic [15:0]       b_data_s;
  logic [15:0]       c_data_s;
  logic [15:0]       b_sum_s;
  logic [15:0]       alu_s;
  logic [15:0]       addr_s;
  logic [15:0]       result_r;

  logic              instr_ready_r;
  logic [2:0]        cond_r;
  logic              mem_req_r;
  logic              mem_we_r;
  logic [15:0]       mem_addr_r;
  logic [15:0]       mem_wdata_r;

  logic              wr_en_s;
  logic [2:0]        wr_addr_s;
  logic [15:0]       wr_data_s;
  logic              pc_inc_s;

  execute_sequencer_regfile u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .ra_addr (first_r),
    .rb_addr (second_r),
    .rc_addr (dest_r),
    .ra_data (a_data_s),
    .rb_data (b_data_s),
    .rc_data (c_data_s),
    .we      (wr_en_s),
    .waddr   (wr_addr_s),
    .wdata   (wr_data_s),
    .pc_inc  (pc_inc_s),
    .pc      (pc)
  );

  // Operands and addresses are read from the latched indices; the file is
  // stable from accept until WB so no operand capture is needed.
  always_comb begin
    b_sum_s = b_data_s + offset_r;
    alu_s   = alu_compute(op_r, a_data_s, b_sum_s, offset_r);
    if (wr_r) addr_s = c_data_s + offset_r;
    else      addr_s = a_data_s + offset_r;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= next_state_s;
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (instr_valid) next_state_s = ST_EXEC;
        else             next_state_s = ST_IDLE;
      end
      ST_EXEC: begin
        if (rd_r || wr_r) next_state_s = ST_MEM;
        else              next_state_s = ST_WB;
      end
      ST_MEM: begin
        if (mem_ack) next_state_s = ST_WB;
        else         next_state_s = ST_MEM;
      end
      ST_WB:   next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Bundle capture on accept and result capture from the ALU or the load return.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dest_r   <= 3'd0;
      first_r  <= 3'd0;
      second_r <= 3'd0;
      offset_r <= 16'd0;
      op_r     <= 3'd0;
      rd_r     <= 1'b0;
      wr_r     <= 1'b0;
      result_r <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (instr_valid) begin
            dest_r   <= destination_reg;
            first_r  <= first_reg;
            second_r <= second_reg;
            offset_r <= offset;
            op_r     <= alu_op;
            rd_r     <= ram_read;
            wr_r     <= ram_write;
          end
        end
        ST_EXEC: result_r <= alu_s;
        ST_MEM:  if (mem_ack) result_r <= mem_rdata;
        default: result_r <= result_r;
      endcase
    end
  end

  // RAM interface registers; request is held until the access completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 16'd0;
      mem_wdata_r <= 16'd0;
    end else begin
      case (state_r)
        ST_EXEC: begin
          if (rd_r || wr_r) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= wr_r;
            mem_addr_r  <= addr_s;
            mem_wdata_r <= a_data_s;
          end
        end
        ST_MEM:  if (mem_ack) mem_req_r <= 1'b0;
        default: mem_req_r <= 1'b0;
      endcase
    end
  end

  // Writeback: a non-store targeting the PC is a jump, everything else steps the PC.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = dest_r;
    wr_data_s = result_r;
    pc_inc_s  = 1'b0;
    if (state_r == ST_WB) begin
      if ((dest_r == PC_REG) && !wr_r) begin
        wr_en_s = 1'b1;
      end else begin
        pc_inc_s = 1'b1;
        wr_en_s  = !wr_r;
      end
    end else begin
      wr_en_s  = 1'b0;
      pc_inc_s = 1'b0;
    end
  end

  // Ready tracks the upcoming IDLE state; flags change only on plain ALU results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_ready_r <= 1'b1;
      cond_r        <= 3'b000;
    end else begin
      instr_ready_r <= (next_state_s == ST_IDLE);
      if ((state_r == ST_WB) && !rd_r && !wr_r &&
          (dest_r != REG_ZERO) && (dest_r != PC_REG)) begin
        cond_r <= flags_of(result_r);
      end
    end
  end

  assign instr_ready = instr_ready_r;
  assign cond_bits   = cond_r;
  assign mem_req     = mem_req_r;
  assign mem_we      = mem_we_r;
  assign mem_addr    = mem_addr_r;
  assign mem_wdata   = mem_wdata_r;

endmodule
